// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, per-button debounce, press/release pulses, sticky press irq
module btn_debounce #(
  parameter int                 NUM_BTN         = 6,
  parameter int                 CNT_WIDTH       = 16,
  parameter int                 DEBOUNCE_CYCLES = 16000,
  parameter logic [NUM_BTN-1:0] IRQ_MASK        = {NUM_BTN{1'b1}}
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               kbd_disc_i,
  output logic [NUM_BTN-1:0] btn_sys_o,
  output logic [NUM_BTN-1:0] btn_usr_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic               irq_o,
  input  logic               irq_ack_i
);

  // Count value at which a differing sample is accepted as the new level.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]   sync1_q;
  logic [NUM_BTN-1:0]   sync2_q;
  logic [NUM_BTN-1:0]   stable_q;
  logic [NUM_BTN-1:0]   stable_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0]   press_q;
  logic [NUM_BTN-1:0]   press_d;
  logic [NUM_BTN-1:0]   release_q;
  logic [NUM_BTN-1:0]   release_d;
  logic                 irq_q;
  logic                 irq_d;

  // Bring the asynchronous active-low pins into clk_i; released (1) is the safe reset level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-button stability counter: any sample matching the stable level restarts the count.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i]  = sync2_q[i];
          press_d[i]   = ~sync2_q[i];
          release_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // A masked press sets the request; a coincident ack loses to the set.
  always_comb begin
    irq_d = irq_q;
    if (|(press_q & IRQ_MASK)) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  // Debounce state, registered event pulses and the sticky interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q  <= '1;
      press_q   <= '0;
      release_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The user view is forced released while the keyboard is unplugged; the system view never is.
  assign btn_sys_o = stable_q;
  assign btn_usr_o = stable_q | {NUM_BTN{kbd_disc_i}};
  assign press_o   = press_q;
  assign release_o = release_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce
module tb_btn_debounce;

  logic       clk;
  logic       rst;
  logic [5:0] btn;
  logic       kbd;
  logic       ack;
  logic [5:0] sys_o, usr_o, press, rel;
  logic       irq;

  logic [5:0] btn_m;
  logic       kbd_m;
  logic       ack_m;
  logic [5:0] sys_m, usr_m, press_m, rel_m;
  logic       irq_m;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c;

  typedef struct {
    int         cyc;
    logic [5:0] p;
    logic [5:0] r;
    logic [5:0] s;
  } ev_t;

  ev_t exp_q[$];

  btn_debounce #(.NUM_BTN(6), .CNT_WIDTH(16), .DEBOUNCE_CYCLES(4), .IRQ_MASK(6'b111111)) u_dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .kbd_disc_i(kbd),
    .btn_sys_o(sys_o), .btn_usr_o(usr_o), .press_o(press), .release_o(rel),
    .irq_o(irq), .irq_ack_i(ack)
  );

  btn_debounce #(.NUM_BTN(6), .CNT_WIDTH(16), .DEBOUNCE_CYCLES(4), .IRQ_MASK(6'b000001)) u_msk (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_m), .kbd_disc_i(kbd_m),
    .btn_sys_o(sys_m), .btn_usr_o(usr_m), .press_o(press_m), .release_o(rel_m),
    .irq_o(irq_m), .irq_ack_i(ack_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int when, input logic [5:0] p, input logic [5:0] r, input logic [5:0] s);
    ev_t e;
    e.cyc = when;
    e.p   = p;
    e.r   = r;
    e.s   = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents is matched against the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && ((press | rel) != 6'h0)) begin
      chk("pulse_exclusive", 32'(press & rel), 32'h0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: press=%0h release=%0h at cycle %0d, none expected", press, rel, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("event_press", 32'(press), 32'(e.p));
        chk("event_release", 32'(rel), 32'(e.r));
        chk("event_sys", 32'(sys_o), 32'(e.s));
      end
    end
  end

  initial begin
    rst = 1'b1; btn = 6'h3F; kbd = 1'b0; ack = 1'b0;
    btn_m = 6'h3F; kbd_m = 1'b0; ack_m = 1'b0;
    #1;
    chk("reset_sys", 32'(sys_o), 32'h3F);
    chk("reset_usr", 32'(usr_o), 32'h3F);
    chk("reset_press", 32'(press), 32'h0);
    chk("reset_release", 32'(rel), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    // Clean press of bit 0
    c = cyc; btn = 6'h3E;
    push(c + 6, 6'h01, 6'h00, 6'h3E);
    repeat (5) step();
    chk("press_not_early", 32'(sys_o), 32'h3F);
    step();
    chk("press_sys", 32'(sys_o), 32'h3E);
    chk("press_usr", 32'(usr_o), 32'h3E);
    chk("press_irq_lag", 32'(irq), 32'h0);
    step();
    chk("press_irq", 32'(irq), 32'h1);
    chk("press_one_cycle", 32'(press), 32'h0);

    // Bounce on bit 2: a run of 3 then a glitch, then 4 clean zeros
    c = cyc;
    push(c + 10, 6'h04, 6'h00, 6'h3A);
    for (int j = 0; j < 8; j++) begin
      btn = (j == 3) ? 6'h3E : 6'h3A;
      step();
    end
    repeat (3) step();
    chk("bounce_sys", 32'(sys_o), 32'h3A);

    // Release bit 0, then ack handling
    c = cyc; btn = 6'h3B;
    push(c + 6, 6'h00, 6'h01, 6'h3B);
    repeat (7) step();
    chk("release_irq_hold", 32'(irq), 32'h1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_clears", 32'(irq), 32'h0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_idle", 32'(irq), 32'h0);
    c = cyc; btn = 6'h39;
    push(c + 6, 6'h02, 6'h00, 6'h39);
    repeat (6) step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("set_wins", 32'(irq), 32'h1);
    step();
    chk("set_sticky", 32'(irq), 32'h1);

    // Simultaneous release of bits 1,2 and press of bits 3,4; then keyboard disconnect
    c = cyc; btn = 6'h27;
    push(c + 6, 6'h18, 6'h06, 6'h27);
    repeat (7) step();
    kbd = 1'b1; #1;
    chk("disc_usr", 32'(usr_o), 32'h3F);
    chk("disc_sys", 32'(sys_o), 32'h27);
    step();
    chk("disc_usr_hold", 32'(usr_o), 32'h3F);
    kbd = 1'b0; #1;
    chk("reconnect_usr", 32'(usr_o), 32'h27);

    // Masked press of bit 5 on the mask-only-bit-0 instance
    btn_m = 6'h1F;
    repeat (6) step();
    chk("mask_press", 32'(press_m), 32'h20);
    chk("mask_sys", 32'(sys_m), 32'h1F);
    step();
    chk("mask_irq", 32'(irq_m), 32'h0);
    chk("mask_pulse_end", 32'(press_m), 32'h0);

    // Reset after two differing samples on bit 0
    btn = 6'h26;
    repeat (4) step();
    rst = 1'b1; #1;
    chk("rst_sys", 32'(sys_o), 32'h3F);
    chk("rst_usr", 32'(usr_o), 32'h3F);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_release", 32'(rel), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    step(); step();
    rst = 1'b0;
    c = cyc;
    push(c + 6, 6'h19, 6'h00, 6'h26);
    repeat (5) step();
    chk("rst_not_early", 32'(sys_o), 32'h3F);
    step();
    chk("rst_press_sys", 32'(sys_o), 32'h26);
    step();
    chk("rst_irq_set", 32'(irq), 32'h1);

    repeat (4) step();
    chk("events_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Front-end conditioning stage for the game-console buttons.
- Sits between the raw button pins and both the core `buttons` bus and the port A PIO `io_i` inputs.
- Synchronises each active-low pin into the system clock domain and debounces it with a per-button stability counter.
- Produces a system view and a user view of the button states, press/release event pulses, and a sticky press interrupt. The user view is forced released while the keyboard is disconnected.

Parameters:
- NUM_BTN, 6, number of buttons; bit order is caller-defined (top uses {BACK, OK, UP, DN, LEFT, RIGHT}).
- CNT_WIDTH, 16, width of each per-button stability counter.
- DEBOUNCE_CYCLES, 16000, consecutive differing samples required to accept a new level (1 ms at 16 MHz). Legal range is 1 to 2^CNT_WIDTH-1.
- IRQ_MASK, {NUM_BTN{1'b1}}, per-button enable of press events into irq_o.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous active-high reset.
- btn_i  input  NUM_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk_i.
- kbd_disc_i  input  1  keyboard disconnect, synchronous to clk_i; 1 forces btn_usr_o to all released.
- btn_sys_o  output  NUM_BTN  debounced state, active-low, never masked.
- btn_usr_o  output  NUM_BTN  btn_sys_o OR {NUM_BTN{kbd_disc_i}}, combinational from registered state.
- press_o  output  NUM_BTN  one-cycle pulse per button on an accepted 1->0 transition.
- release_o  output  NUM_BTN  one-cycle pulse per button on an accepted 0->1 transition.
- irq_o  output  1  sticky interrupt request, set by masked press events.
- irq_ack_i  input  1  single-cycle clear of irq_o.

Behaviour:
- Reset is asynchronous on rst_i; all state returns to its reset value immediately.
  - Sync flops, stable state and btn_sys_o reset to all 1 (released).
  - Counters reset to 0; press_o, release_o and irq_o reset to 0.
  - btn_usr_o is therefore all 1 during reset.
- Synchroniser: 2 flops per button (s1 <= btn_i; s2 <= s1). Only s2 feeds the debouncer.
- Per-button debounce, evaluated every clk_i edge:
  - If s2 == stable: cnt <= 0, no event.
  - If s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, and the event pulse fires in the same cycle that stable updates (press_o if s2==0, release_o if s2==1).
  - Any single sample with s2 == stable restarts the count from 0.
  - With DEBOUNCE_CYCLES = 1, stable flips on the first differing s2 sample.
- Latency: a clean pin step becomes visible on btn_sys_o 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples the new pin level.
- Each button has its own independent counter. Several buttons may accept transitions in the same cycle, and their pulses assert together.
- Pulses: press_o[i] and release_o[i] are registered, high for exactly one cycle, and never both high for the same bit.
- Interrupt:
  - Set condition: |(press_o & IRQ_MASK) is high. irq_o goes to 1 the cycle after the set condition.
  - irq_ack_i clears irq_o the following cycle.
  - If set and ack occur in the same cycle, set wins and irq_o stays 1.
  - Ack while irq_o = 0 has no effect.
- Keyboard disconnect:
  - kbd_disc_i only affects btn_usr_o, with 0 cycles of latency.
  - Debouncing, btn_sys_o, pulses and irq_o continue unaffected, so the system keeps seeing the buttons.
- Reset mid-count: the count is discarded and the button returns to released. After reset release, a still-held button needs the full 2 + DEBOUNCE_CYCLES edges to register as pressed, and produces a press_o pulse when it does.
- Counter never wraps; it is bounded by DEBOUNCE_CYCLES-1 < 2^CNT_WIDTH.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, NUM_BTN=6, IRQ_MASK=6'b111111 unless stated.
1. Clean press: btn_i 6'h3F -> 6'h3E, held.
   - btn_sys_o = 6'h3E exactly 6 edges later.
   - press_o = 6'h01 for 1 cycle; irq_o = 1 on the next cycle; release_o stays 0.
2. Bounce: bit 2 toggles 0,0,0,1,0,0,0,0 (one sample per cycle after sync).
   - The first run of 3 is rejected.
   - stable flips only after 4 consecutive zeros; exactly one press_o[2] pulse.
3. Release and ack:
   - From pressed bit 0, set btn_i = 6'h3F -> release_o = 6'h01 pulse, no irq change.
   - Assert irq_ack_i -> irq_o = 0 the next cycle.
   - Ack coincident with a new press event -> irq_o stays 1.
4. Disconnect: hold bits 3 and 4 pressed (btn_sys_o = 6'h27), then drive kbd_disc_i = 1.
   - btn_usr_o = 6'h3F in the same cycle; btn_sys_o remains 6'h27.
   - kbd_disc_i = 0 -> btn_usr_o = 6'h27.
5. Mask: IRQ_MASK = 6'b000001, press bit 5.
   - press_o = 6'h20 pulse; irq_o stays 0.
6. Reset mid-count: assert rst_i after 2 differing samples on a held button.
   - All outputs return to reset values immediately.
   - After deassert, press is accepted 6 edges later with one press_o pulse.
